// File: rtl/keypad_scan_ctrl.sv
// Purpose: 4x4 keypad scanner; strobes columns, samples synchronised rows, debounces whole sweeps into key events.
// Latency: key_valid on the edge after the accepting sweep; stable press to pulse <= (DEBOUNCE_SCANS+1)*4*SCAN_DIV+3 cycles.
// Backpressure: none; key_valid is a one-cycle pulse that the consumer must take when it is presented.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] shift_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_TGT  = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] div;
  logic [1:0]    col_idx, col_nxt;
  logic          div_tc, sweep_done;
  logic [3:0]    low;
  logic [2:0]    low_n, tot_n;
  logic [1:0]    row_idx;
  logic [1:0]    acc_n;
  logic [3:0]    acc_code, cur_code;
  logic          sweep_one, sweep_none;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    cand;

  assign div_tc     = (div == DIV_LAST);
  assign col_nxt    = div_tc ? col_idx + 2'd1 : col_idx;
  assign sweep_done = div_tc && (col_idx == 2'd3);

  // Two-flop synchroniser; idle (all released) is all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  // Column divider and strobe; shift_col is loaded with the column that will be current next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div       <= '0;
      col_idx   <= 2'd0;
      shift_col <= 4'b0111;
    end else begin
      div       <= div_tc ? '0 : div + DW'(1);
      col_idx   <= col_nxt;
      shift_col <= ~(4'b1000 >> col_nxt);
    end
  end

  // Decode the current column's sample and fold it into the running sweep totals.
  always_comb begin
    low     = ~row_s2;
    low_n   = {2'b00, low[0]} + {2'b00, low[1]} + {2'b00, low[2]} + {2'b00, low[3]};
    row_idx = 2'd3;
    if (low[3])      row_idx = 2'd0;
    else if (low[2]) row_idx = 2'd1;
    else if (low[1]) row_idx = 2'd2;
    tot_n    = {1'b0, acc_n} + low_n;
    cur_code = (low_n == 3'd1) ? {col_idx, row_idx} : acc_code;
    sweep_one  = (tot_n == 3'd1);
    sweep_none = (tot_n == 3'd0);
  end

  // Per-sweep accumulator: low-bit count saturates at 2 (anything above one key is MULTI).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_n    <= 2'd0;
      acc_code <= 4'd0;
    end else if (div_tc) begin
      if (col_idx == 2'd3) begin
        acc_n    <= 2'd0;
        acc_code <= 4'd0;
      end else begin
        acc_n    <= (tot_n >= 3'd2) ? 2'd2 : tot_n[1:0];
        acc_code <= cur_code;
      end
    end
  end

  // Debounce FSM, advanced once per completed sweep; no new key is accepted without a full release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cand      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (sweep_done) begin
        case (state)
          ST_IDLE: begin
            if (sweep_one) begin
              if (CNT_TGT == CNT_ONE) begin
                key_code  <= cur_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= ST_HELD;
                cnt       <= '0;
              end else begin
                state <= ST_DEBOUNCE;
                cand  <= cur_code;
                cnt   <= CNT_ONE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (!sweep_one) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (cur_code != cand) begin
              cand <= cur_code;
              cnt  <= CNT_ONE;
            end else if (cnt + CNT_ONE == CNT_TGT) begin
              key_code  <= cand;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= ST_HELD;
              cnt       <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_HELD: begin
            if (sweep_none) begin
              if (CNT_TGT == CNT_ONE) begin
                state    <= ST_IDLE;
                key_held <= 1'b0;
                cnt      <= '0;
              end else begin
                state <= ST_RELEASE;
                cnt   <= CNT_ONE;
              end
            end
          end
          ST_RELEASE: begin
            if (!sweep_none) begin
              state <= ST_HELD;
              cnt   <= '0;
            end else if (cnt + CNT_ONE == CNT_TGT) begin
              state    <= ST_IDLE;
              key_held <= 1'b0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Purpose: directed bench for keypad_scan_ctrl with a sweep-level reference model checked every cycle.
// Latency: model predicts registered outputs one cycle ahead from the rows actually driven.
// Backpressure: not applicable; the bench consumes every key_valid pulse.
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row = 4'hF;
  logic [3:0] shift_col, key_code;
  logic       key_valid, key_held;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .reset(reset), .row(row), .shift_col(shift_col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Keypad model: which key(s) are down
  logic       key_on = 1'b0;
  int         key_c = 0, key_r = 0;
  logic       multi_on = 1'b0;

  task automatic drive_row();
    logic [3:0] r;
    logic [3:0] col_pat;
    logic [3:0] row_pat;
    r = 4'hF;
    col_pat = ~(4'b1000 >> key_c);
    row_pat = ~(4'b1000 >> key_r);
    if (key_on && shift_col == col_pat) r = r & row_pat;
    if (multi_on && shift_col == 4'b0111) r = r & 4'b1001;
    row = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_row();
  endtask

  task automatic run_sweeps(input int n);
    repeat (16 * n) tick();
  endtask

  task automatic press(input int c, input int r);
    key_on = 1'b1; key_c = c; key_r = r;
    drive_row();
  endtask

  task automatic release_all();
    key_on = 1'b0; multi_on = 1'b0;
    drive_row();
  endtask

  // Reference model state
  int         t = 0;
  logic       m_held = 1'b0;
  int         m_run = 0;
  logic [3:0] m_cand = 4'd0;
  int         acc_n = 0;
  logic [3:0] acc_code = 4'd0;
  logic [3:0] rm1 = 4'hF, rm2 = 4'hF;
  logic [3:0] e_shift = 4'b0111, e_code = 4'd0;
  logic       e_valid = 1'b0, e_held = 1'b0;
  int         pulse_cnt = 0;
  int         last_pulse_t = -1;

  // Compare process: checks DUT against the model each cycle, then advances the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_shift_col", shift_col, 4'b0111);
      check("rst_key_code", key_code, 4'd0);
      check("rst_key_valid", key_valid, 1'b0);
      check("rst_key_held", key_held, 1'b0);
      t = 0; m_held = 1'b0; m_run = 0; m_cand = 4'd0;
      acc_n = 0; acc_code = 4'd0; rm1 = 4'hF; rm2 = 4'hF;
      e_shift = 4'b0111; e_code = 4'd0; e_valid = 1'b0; e_held = 1'b0;
    end else begin
      check("shift_col", shift_col, e_shift);
      check("key_code", key_code, e_code);
      check("key_valid", key_valid, e_valid);
      check("key_held", key_held, e_held);
      if (key_valid === 1'b1) begin
        pulse_cnt++;
        last_pulse_t = t;
      end
      e_valid = 1'b0;
      if (t % SD == SD - 1) begin
        int col;
        col = (t / SD) % 4;
        for (int i = 0; i < 4; i++) begin
          if (rm2[3 - i] == 1'b0) begin
            acc_n++;
            acc_code = {col[1:0], 2'(i)};
          end
        end
        if (col == 3) begin
          if (acc_n == 1) begin
            if (!m_held) begin
              if (m_run > 0 && acc_code == m_cand) m_run++;
              else begin m_cand = acc_code; m_run = 1; end
              if (m_run == DS) begin
                m_held = 1'b1; m_run = 0; e_valid = 1'b1; e_code = m_cand;
              end
            end else m_run = 0;
          end else if (acc_n == 0) begin
            if (m_held) begin
              m_run++;
              if (m_run == DS) begin m_held = 1'b0; m_run = 0; end
            end else m_run = 0;
          end else m_run = 0;
          e_held = m_held;
          acc_n = 0;
        end
      end
      rm2 = rm1;
      rm1 = row;
      t++;
      e_shift = ~(4'b1000 >> ((t / SD) % 4));
    end
  end

  int p0;

  initial begin
    reset = 1'b0;
    row = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;                          // cycle 0
    #1;
    check("idle_c0_shift", shift_col, 4'b0111);
    repeat (4) tick();
    check("idle_c4_shift", shift_col, 4'b1011);
    repeat (4) tick();
    check("idle_c8_shift", shift_col, 4'b1101);
    repeat (4) tick();
    check("idle_c12_shift", shift_col, 4'b1110);
    repeat (4) tick();
    check("idle_c16_shift", shift_col, 4'b0111);
    repeat (16) tick();                    // cycle 32, sweep boundary

    // Stable press col1/row2 for 4 sweeps
    p0 = pulse_cnt;
    press(1, 2);
    run_sweeps(4);
    #5;
    check("press_pulses", pulse_cnt - p0, 1);
    check("press_pulse_cycle", last_pulse_t, 64);
    check("press_code", key_code, 4'b0110);
    check("press_held", key_held, 1'b1);
    release_all();
    run_sweeps(2);
    #5;
    check("release_held", key_held, 1'b0);

    // Bouncing col3/row0: 1 sweep on, 1 sweep off, three times
    p0 = pulse_cnt;
    repeat (3) begin
      press(3, 0);
      run_sweeps(1);
      release_all();
      run_sweeps(1);
    end
    #5;
    check("bounce_pulses", pulse_cnt - p0, 0);
    check("bounce_held", key_held, 1'b0);

    // Accept, short release, re-press, full release, new key
    p0 = pulse_cnt;
    press(2, 1);
    run_sweeps(2);
    #5;
    check("acc_pulses", pulse_cnt - p0, 1);
    check("acc_code", key_code, 4'b1001);
    p0 = pulse_cnt;
    release_all();
    run_sweeps(1);
    press(2, 1);
    run_sweeps(1);
    #5;
    check("repress_pulses", pulse_cnt - p0, 0);
    check("repress_held", key_held, 1'b1);
    release_all();
    run_sweeps(2);
    #5;
    check("full_release_held", key_held, 1'b0);
    p0 = pulse_cnt;
    press(0, 3);
    run_sweeps(2);
    #5;
    check("new_key_pulses", pulse_cnt - p0, 1);
    check("new_key_code", key_code, 4'b0011);
    release_all();
    run_sweeps(2);

    // Two keys in col0 at once
    p0 = pulse_cnt;
    multi_on = 1'b1;
    drive_row();
    run_sweeps(4);
    #5;
    check("multi_pulses", pulse_cnt - p0, 0);
    check("multi_code_kept", key_code, 4'b0011);
    release_all();
    run_sweeps(1);

    // Reset in the middle of debounce
    press(1, 2);
    run_sweeps(1);
    repeat (5) tick();
    reset = 1'b0;
    #1;
    check("mid_rst_shift", shift_col, 4'b0111);
    check("mid_rst_code", key_code, 4'd0);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_held", key_held, 1'b0);
    repeat (3) tick();
    reset = 1'b1;                          // fresh cycle 0
    p0 = pulse_cnt;
    repeat (31) tick();
    #5;
    check("post_rst_early", pulse_cnt - p0, 0);
    tick();
    #5;
    check("post_rst_pulses", pulse_cnt - p0, 1);
    check("post_rst_cycle", last_pulse_t, 32);
    check("post_rst_code", key_code, 4'b0110);
    release_all();
    run_sweeps(2);
    #5;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
